// File: rtl/tx_arbitro_serial.sv
// Round-robin arbiter sharing one tx_serial_7O1 between two character requesters.
// Captures the winner's character, fires partida, then waits for pronto or a timeout.
module tx_arbitro_serial #(
  parameter int TIMEOUT_CICLOS = 6000,
  parameter int W_TIMER        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedido0,
  input  logic [6:0] dados0,
  input  logic       pedido1,
  input  logic [6:0] dados1,
  output logic       concedido0,
  output logic       concedido1,
  output logic       fim0,
  output logic       fim1,
  output logic       tx_partida,
  output logic [6:0] tx_dados,
  input  logic       tx_pronto,
  output logic       erro_timeout,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    ESPERA    = 3'd1,
    CARREGA   = 3'd2,
    PARTIDA   = 3'd3,
    TRANSMITE = 3'd4,
    FIM       = 3'd5,
    ERRO      = 3'd6
  } estado_t;

  localparam logic [W_TIMER-1:0] LIMITE = W_TIMER'(TIMEOUT_CICLOS - 1);

  estado_t             estado, prox;
  logic                sel, ultimo;
  logic [W_TIMER-1:0]  timer;
  logic                algum_pedido, vencedor;

  // On a tie the channel that was not served last wins.
  assign algum_pedido = pedido0 | pedido1;
  assign vencedor     = (pedido0 & pedido1) ? ~ultimo : pedido1;

  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:   prox = ESPERA;
      ESPERA:    if (algum_pedido) prox = CARREGA;
      CARREGA:   prox = PARTIDA;
      PARTIDA:   prox = TRANSMITE;
      TRANSMITE: begin
        if (tx_pronto)          prox = FIM;
        else if (timer == LIMITE) prox = ERRO;
      end
      FIM:       prox = ESPERA;
      ERRO:      prox = ESPERA;
      default:   prox = INICIAL;
    endcase
  end

  // Datapath: winner capture, frame timer and round-robin memory.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel      <= 1'b0;
      ultimo   <= 1'b1;
      tx_dados <= '0;
      timer    <= '0;
    end else begin
      case (estado)
        ESPERA: if (algum_pedido) begin
          sel      <= vencedor;
          tx_dados <= vencedor ? dados1 : dados0;
        end
        PARTIDA:   timer <= '0;
        TRANSMITE: if (!tx_pronto && timer != LIMITE) timer <= timer + 1'b1;
        FIM, ERRO: ultimo <= sel;
        default: ;
      endcase
    end
  end

  always_comb begin
    concedido0   = 1'b0;
    concedido1   = 1'b0;
    fim0         = 1'b0;
    fim1         = 1'b0;
    tx_partida   = 1'b0;
    erro_timeout = 1'b0;
    ocupado      = 1'b0;
    db_estado    = estado;
    case (estado)
      CARREGA: begin
        concedido0 = ~sel;
        concedido1 = sel;
        ocupado    = 1'b1;
      end
      PARTIDA: begin
        tx_partida = 1'b1;
        ocupado    = 1'b1;
      end
      TRANSMITE: ocupado = 1'b1;
      FIM: begin
        fim0    = ~sel;
        fim1    = sel;
        ocupado = 1'b1;
      end
      ERRO: begin
        erro_timeout = 1'b1;
        ocupado      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_arbitro_serial.sv
// Directed bench for tx_arbitro_serial: reset, latency, alternation, timeout boundary, mid-frame reset.
module tb_tx_arbitro_serial;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pedido0 = 1'b0, pedido1 = 1'b0;
  logic [6:0] dados0 = '0, dados1 = '0;
  logic       concedido0, concedido1, fim0, fim1, tx_partida, erro_timeout, ocupado;
  logic [6:0] tx_dados;
  logic       tx_pronto = 1'b0;
  logic [2:0] db_estado;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_fim0 = 0, cnt_fim1 = 0, cnt_erro = 0;

  tx_arbitro_serial #(.TIMEOUT_CICLOS(6000), .W_TIMER(13)) dut (
    .clock(clock), .reset(reset),
    .pedido0(pedido0), .dados0(dados0), .pedido1(pedido1), .dados1(dados1),
    .concedido0(concedido0), .concedido1(concedido1), .fim0(fim0), .fim1(fim1),
    .tx_partida(tx_partida), .tx_dados(tx_dados), .tx_pronto(tx_pronto),
    .erro_timeout(erro_timeout), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #10 clock = ~clock;

  // Pulse tallies, sampled at the end of each cycle.
  always @(posedge clock) begin
    if (fim0)         cnt_fim0++;
    if (fim1)         cnt_fim1++;
    if (erro_timeout) cnt_erro++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a selected output to go high; returns cycles waited.
  task automatic wait_high(input int which, input int budget, input string tag, output int waited);
    logic hit;
    waited = 0;
    hit = 1'b0;
    while (!hit && waited < budget) begin
      @(negedge clock);
      waited++;
      case (which)
        0: hit = concedido0;
        1: hit = concedido1;
        2: hit = tx_partida;
        default: hit = concedido0 | concedido1;
      endcase
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pronto_pulse;
    tx_pronto = 1'b1;
    @(negedge clock);
    tx_pronto = 1'b0;
  endtask

  initial begin
    int w, f1, f0, e0;
    logic exp_ch;
    logic [6:0] exp_d;

    // 1. reset held low
    repeat (20) @(negedge clock);
    check("rst_estado", db_estado, 3'd0);
    check("rst_outs", {concedido0, concedido1, fim0, fim1, tx_partida, erro_timeout, ocupado},
          7'd0);
    check("rst_dados", tx_dados, 7'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_espera", db_estado, 3'd1);

    // 2. single ch0 request, latency and capture
    pedido0 = 1'b1; dados0 = 7'h35;
    f1 = cnt_fim1;
    wait_high(0, 4, "t2_conc0", w);
    check("t2_conc_lat", w, 1);
    check("t2_conc1_low", concedido1, 1'b0);
    check("t2_ocupado", ocupado, 1'b1);
    pedido0 = 1'b0; dados0 = 7'h00;
    @(negedge clock);
    check("t2_partida", tx_partida, 1'b1);
    check("t2_dados", tx_dados, 7'h35);
    repeat (4800) @(negedge clock);
    check("t2_no_fim_yet", fim0, 1'b0);
    pronto_pulse();
    check("t2_fim0", fim0, 1'b1);
    check("t2_estado_fim", db_estado, 3'd5);
    @(negedge clock);
    check("t2_back_espera", db_estado, 3'd1);
    check("t2_fim1_never", cnt_fim1 - f1, 0);

    // 4. ch1 timeout, no pronto
    pedido1 = 1'b1; dados1 = 7'h7F;
    f1 = cnt_fim1; e0 = cnt_erro;
    wait_high(1, 4, "t4_conc1", w);
    pedido1 = 1'b0;
    @(negedge clock);
    check("t4_partida", tx_partida, 1'b1);
    check("t4_dados", tx_dados, 7'h7F);
    repeat (6000) @(negedge clock);
    check("t4_erro_early", erro_timeout, 1'b0);
    check("t4_estado_tx", db_estado, 3'd4);
    @(negedge clock);
    check("t4_erro", erro_timeout, 1'b1);
    check("t4_estado_erro", db_estado, 3'd6);
    @(negedge clock);
    check("t4_espera", db_estado, 3'd1);
    check("t4_erro_once", cnt_erro - e0, 1);
    check("t4_no_fim1", cnt_fim1 - f1, 0);

    // 3. both channels held, grants alternate starting at ch0
    pedido0 = 1'b1; dados0 = 7'h55;
    pedido1 = 1'b1; dados1 = 7'h7E;
    for (int fr = 0; fr < 4; fr++) begin
      exp_ch = fr[0];
      exp_d  = exp_ch ? 7'h7E : 7'h55;
      wait_high(3, 4, "t3_conc", w);
      check("t3_conc_ch", concedido1, exp_ch);
      @(negedge clock);
      check("t3_dados", tx_dados, exp_d);
      repeat (10) @(negedge clock);
      pronto_pulse();
      check("t3_fim", exp_ch ? fim1 : fim0, 1'b1);
      if (fr == 3) begin
        pedido0 = 1'b0; pedido1 = 1'b0;
      end
    end
    @(negedge clock);
    check("t3_idle", db_estado, 3'd1);

    // 5. pronto coincident with timer at limit
    pedido0 = 1'b1; dados0 = 7'h41;
    e0 = cnt_erro; f0 = cnt_fim0;
    wait_high(0, 4, "t5_conc0", w);
    pedido0 = 1'b0;
    @(negedge clock);
    check("t5_partida", tx_partida, 1'b1);
    repeat (6000) @(negedge clock);
    pronto_pulse();
    check("t5_fim0", fim0, 1'b1);
    check("t5_no_erro", erro_timeout, 1'b0);
    @(negedge clock);
    check("t5_erro_count", cnt_erro - e0, 0);
    check("t5_fim_count", cnt_fim0 - f0, 1);

    // 6. reset mid-transmission, then normal service
    pedido0 = 1'b1; dados0 = 7'h11;
    f0 = cnt_fim0; e0 = cnt_erro;
    wait_high(0, 4, "t6_conc0", w);
    pedido0 = 1'b0;
    @(negedge clock);
    check("t6_partida", tx_partida, 1'b1);
    repeat (100) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t6_estado", db_estado, 3'd0);
    check("t6_outs", {tx_partida, fim0, fim1, erro_timeout, ocupado}, 5'd0);
    reset = 1'b1;
    @(negedge clock);
    check("t6_espera", db_estado, 3'd1);
    check("t6_no_pulses", (cnt_fim0 - f0) + (cnt_erro - e0), 0);
    pedido1 = 1'b1; dados1 = 7'h2A;
    wait_high(1, 4, "t6_conc1", w);
    check("t6_conc_lat", w, 1);
    pedido1 = 1'b0;
    @(negedge clock);
    check("t6_dados", tx_dados, 7'h2A);
    repeat (20) @(negedge clock);
    pronto_pulse();
    check("t6_fim1", fim1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
